multi_ch_sync_fifo: RTL and testbench
=====================================

Name: multi_ch_sync_fifo

Overview:
Single-clock, multi-channel FIFO for the convolution datapath. It buffers NUM_CH independent streams (e.g. feature-map lines or per-kernel partial sums) in one shared memory that is partitioned per channel. Each cycle it accepts at most one write and one read, to any channels. Compared with the dual-clock FIFO it adds a channel count, per-channel occupancy and threshold flags, per-channel flush, and sticky error reporting.

Parameters:
DATA_WIDTH, 8, width of one FIFO word
FIFO_DEPTH, 16, entries per channel; power of 2, at least 2
NUM_CH, 4, number of independent channels; at least 1
AF_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH
(derived) ADDR_WIDTH=$clog2(FIFO_DEPTH); CNT_W=ADDR_WIDTH+1; CH_W=max(1,$clog2(NUM_CH))

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  NUM_CH  per-channel flush request
err_clr  in  1  clears both sticky error flags
wr_valid  in  1  write request
wr_ch  in  CH_W  target channel for the write
wr_data  in  DATA_WIDTH  write data
wr_ready  out  1  write will be accepted this cycle
rd_req  in  1  read (pop) request
rd_ch  in  CH_W  source channel for the read
rd_valid  out  1  rd_data is valid
rd_data  out  DATA_WIDTH  read data
rd_count  out  CNT_W  occupancy of rd_ch (combinational from registered count)
full  out  NUM_CH  per-channel full (count==FIFO_DEPTH)
empty  out  NUM_CH  per-channel empty (count==0)
almost_full  out  NUM_CH  per-channel count >= AF_THRESH
almost_empty  out  NUM_CH  per-channel count <= AE_THRESH
err_ovf  out  1  sticky: write attempted to a full channel
err_udf  out  1  sticky: read attempted from an empty channel

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). Reset acts only at a clk edge where rst_n=0.
- Reset values:
  - all wr/rd pointers and counts = 0
  - empty = all 1, full = 0, almost_empty = all 1 (AE_THRESH >= 0), almost_full = 0
  - rd_valid = 0, rd_data = 0, err_ovf = err_udf = 0
  - memory contents are not reset
- Storage: NUM_CH*FIFO_DEPTH words; address = {ch, ptr[ADDR_WIDTH-1:0]}. Per-channel binary pointers wrap modulo FIFO_DEPTH. The count register (CNT_W bits) distinguishes full from empty.
- Write: wr_ready = !full[wr_ch] && !flush[wr_ch] && (wr_ch < NUM_CH). Write is accepted when wr_valid && wr_ready: data stored at the head of the channel, wr_ptr+1, count+1.
- Read: accepted when rd_req && !empty[rd_ch] && !flush[rd_ch] && (rd_ch < NUM_CH). The word is popped, rd_ptr+1, count-1. rd_data is registered and rd_valid=1 on the next cycle (latency 1). Otherwise rd_valid=0 next cycle and rd_data holds its last value.
- Flags are evaluated from registered counts only; there is no same-cycle bypass:
  - write to a full channel with a concurrent read of the same channel: write rejected, read accepted
  - read from an empty channel with a concurrent write to the same channel: read rejected, write accepted
- Same-channel read and write both accepted: count unchanged, pointers both advance.
- Different channels: each channel updates independently.
- Flush has priority over read and write. Next cycle: that channel's pointers and count = 0. A read or write to the flushed channel in the same cycle is discarded and raises no error. Other channels are untouched.
- Errors:
  - err_ovf set when wr_valid && full[wr_ch] && !flush[wr_ch]
  - err_udf set when rd_req && empty[rd_ch] && !flush[rd_ch]
  - both held until err_clr=1 or reset; if set and clear occur in the same cycle, set wins
  - wr_ch/rd_ch >= NUM_CH: request ignored, no error, no state change
- Reset mid-operation: all in-flight data is lost, and the next cycle after rst_n returns high behaves as post-reset.

Optional Feature:
- Macro FIFO_FWFT_EN. When defined, the FIFO runs in first-word-fall-through mode:
  - rd_data = head of rd_ch, combinational
  - rd_valid = !empty[rd_ch] && !flush[rd_ch] && (rd_ch < NUM_CH), same cycle
  - rd_req acts as an acknowledge that pops at the edge
  - reset value of rd_data is don't-care
- When undefined, reads use the registered 1-cycle-latency behaviour above.

Test Plan:
(DATA_WIDTH=8, FIFO_DEPTH=4, NUM_CH=2, AF_THRESH=3, AE_THRESH=1, non-FWFT)
- Fill: reset, write 0x11,0x22,0x33,0x44 to ch0 -> almost_full[0]=1 after 3rd write, full[0]=1 after 4th, wr_ready=0; 5th write 0x55 -> rejected, err_ovf=1; ch1 stays empty=1.
- Drain: 4 reads of ch0 -> rd_data 0x11,0x22,0x33,0x44, each one cycle after its rd_req with rd_valid=1; empty[0]=1; 5th read -> rd_valid=0, err_udf=1; err_clr -> both errors 0.
- Wrap and concurrency: ch1 holds 2 words; 10 cycles of read+write on ch1 with data 0xA0..0xA9 -> rd_count stays 2, output order preserved across pointer wrap.
- Cross-channel: write ch1 0xB0 while reading ch0 (count 1) in the same cycle -> ch0 empty, ch1 count 1; write to full ch0 with read of ch0 in the same cycle -> write rejected, err_ovf=1, count 3.
- Flush: ch0 count 3, flush[0]=1 with concurrent write 0xCC to ch0 -> next cycle count0=0, empty[0]=1, no error, ch1 unchanged; later read of ch0 returns only newly written data.
- Reset: rst_n pulled low mid-stream between edges -> state unchanged until the next clk edge, then all reset values; rst_n high -> normal operation the following cycle.

Source files
------------

// File: rtl/multi_ch_sync_fifo.sv
// Single-clock multi-channel FIFO: NUM_CH independent queues sharing one partitioned memory.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle-latency reads.
module multi_ch_sync_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int NUM_CH     = 4,
    parameter  int AF_THRESH  = FIFO_DEPTH - 2,
    parameter  int AE_THRESH  = 1,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = ADDR_WIDTH + 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     flush,
    input  logic                  err_clr,
    input  logic                  wr_valid,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    input  logic [CH_W-1:0]       rd_ch,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]      rd_count,
    output logic [NUM_CH-1:0]     full,
    output logic [NUM_CH-1:0]     empty,
    output logic [NUM_CH-1:0]     almost_full,
    output logic [NUM_CH-1:0]     almost_empty,
    output logic                  err_ovf,
    output logic                  err_udf
);

    logic [ADDR_WIDTH-1:0] r_wr_ptr [NUM_CH];
    logic [ADDR_WIDTH-1:0] r_rd_ptr [NUM_CH];
    logic [CNT_W-1:0]      r_count  [NUM_CH];
    logic [DATA_WIDTH-1:0] r_mem    [NUM_CH*FIFO_DEPTH];
    logic                  r_err_ovf;
    logic                  r_err_udf;

    logic                         w_wr_ch_ok;
    logic                         w_rd_ch_ok;
    logic                         w_wr_fire;
    logic                         w_rd_can;
    logic                         w_rd_fire;
    logic                         w_ovf;
    logic                         w_udf;
    logic [NUM_CH-1:0]            w_wr_sel;
    logic [NUM_CH-1:0]            w_rd_sel;
    logic [CH_W+ADDR_WIDTH-1:0]   w_wr_addr;
    logic [CH_W+ADDR_WIDTH-1:0]   w_rd_addr;

    // Flags derive only from registered counts, so a same-cycle push cannot unblock a pop.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]         = (r_count[i] == CNT_W'(FIFO_DEPTH));
            empty[i]        = (r_count[i] == '0);
            almost_full[i]  = (int'(r_count[i]) >= AF_THRESH);
            almost_empty[i] = (int'(r_count[i]) <= AE_THRESH);
        end
    end

    assign w_wr_ch_ok = (int'(wr_ch) < NUM_CH);
    assign w_rd_ch_ok = (int'(rd_ch) < NUM_CH);
    assign wr_ready   = w_wr_ch_ok && !full[wr_ch] && !flush[wr_ch];
    assign w_wr_fire  = wr_valid && wr_ready;
    assign w_rd_can   = w_rd_ch_ok && !empty[rd_ch] && !flush[rd_ch];
    assign w_rd_fire  = rd_req && w_rd_can;
    assign w_ovf      = wr_valid && w_wr_ch_ok && full[wr_ch] && !flush[wr_ch];
    assign w_udf      = rd_req && w_rd_ch_ok && empty[rd_ch] && !flush[rd_ch];
    assign w_wr_addr  = {wr_ch, r_wr_ptr[wr_ch]};
    assign w_rd_addr  = {rd_ch, r_rd_ptr[rd_ch]};
    assign rd_count   = w_rd_ch_ok ? r_count[rd_ch] : '0;
    assign err_ovf    = r_err_ovf;
    assign err_udf    = r_err_udf;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_wr_sel = '0;
        w_rd_sel = '0;
        if (w_wr_fire) w_wr_sel[wr_ch] = 1'b1;
        if (w_rd_fire) w_rd_sel[rd_ch] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (flush[i]) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                    r_count[i]  <= '0;
                end else begin
                    if (w_wr_sel[i]) r_wr_ptr[i] <= r_wr_ptr[i] + ADDR_WIDTH'(1);
                    if (w_rd_sel[i]) r_rd_ptr[i] <= r_rd_ptr[i] + ADDR_WIDTH'(1);
                    if (w_wr_sel[i] && !w_rd_sel[i])
                        r_count[i] <= r_count[i] + CNT_W'(1);
                    else if (!w_wr_sel[i] && w_rd_sel[i])
                        r_count[i] <= r_count[i] - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[w_wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_ovf)        r_err_ovf <= 1'b1;
            else if (err_clr) r_err_ovf <= 1'b0;
            if (w_udf)        r_err_udf <= 1'b1;
            else if (err_clr) r_err_udf <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data  = r_mem[w_rd_addr];
    assign rd_valid = w_rd_can;
`else
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
`endif

endmodule

// File: tb/tb_multi_ch_sync_fifo.sv
// Directed self-checking bench for multi_ch_sync_fifo (DEPTH=4, NUM_CH=2, AF=3, AE=1, registered reads).
module tb_multi_ch_sync_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int NCH = 2;
    localparam int CW = 1;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  flush;
    logic            err_clr;
    logic            wr_valid;
    logic [CW-1:0]   wr_ch;
    logic [DW-1:0]   wr_data;
    logic            wr_ready;
    logic            rd_req;
    logic [CW-1:0]   rd_ch;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [CNTW-1:0] rd_count;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  empty;
    logic [NCH-1:0]  almost_full;
    logic [NCH-1:0]  almost_empty;
    logic            err_ovf;
    logic            err_udf;

    int n_tests = 0;
    int n_fail  = 0;

    multi_ch_sync_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH), .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .err_clr(err_clr),
        .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_count(rd_count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle 1 time unit past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        flush    = '0;
        err_clr  = 1'b0;
    endtask

    task automatic wr(input logic [CW-1:0] ch, input logic [DW-1:0] d);
        wr_valid = 1'b1; wr_ch = ch; wr_data = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [CW-1:0] ch);
        rd_req = 1'b1; rd_ch = ch;
        step();
        idle();
    endtask

    task automatic check_count(input string tag, input logic [CW-1:0] ch, input int exp);
        rd_ch = ch;
        #1;
        check(tag, 32'(rd_count), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; wr_ch = '0; rd_ch = '0; wr_data = '0;
        idle();
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_empty", 32'(empty), 32'h3);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ae", 32'(almost_empty), 32'h3);
        check("rst_af", 32'(almost_full), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_errs", 32'({err_ovf, err_udf}), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);

        // Fill ch0
        wr(0, 8'h11); wr(0, 8'h22);
        check("fill2_af", 32'(almost_full[0]), 32'h0);
        wr(0, 8'h33);
        check("fill3_af", 32'(almost_full[0]), 32'h1);
        check("fill3_full", 32'(full[0]), 32'h0);
        wr(0, 8'h44);
        wr_ch = 0; #1;
        check("fill4_full", 32'(full[0]), 32'h1);
        check("fill4_wr_ready", 32'(wr_ready), 32'h0);
        check("fill4_ae", 32'(almost_empty[0]), 32'h0);
        wr(0, 8'h55);
        check("ovf_set", 32'(err_ovf), 32'h1);
        check_count("ovf_count", 0, 4);
        check("ch1_empty", 32'(empty[1]), 32'h1);

        // Drain ch0
        rd(0); check("drain0_v", 32'(rd_valid), 32'h1); check("drain0_d", 32'(rd_data), 32'h11);
        rd(0); check("drain1_v", 32'(rd_valid), 32'h1); check("drain1_d", 32'(rd_data), 32'h22);
        rd(0); check("drain2_v", 32'(rd_valid), 32'h1); check("drain2_d", 32'(rd_data), 32'h33);
        rd(0); check("drain3_v", 32'(rd_valid), 32'h1); check("drain3_d", 32'(rd_data), 32'h44);
        check("drain_empty", 32'(empty[0]), 32'h1);
        rd(0);
        check("udf_rd_valid", 32'(rd_valid), 32'h0);
        check("udf_hold_data", 32'(rd_data), 32'h44);
        check("udf_set", 32'(err_udf), 32'h1);
        err_clr = 1'b1; step(); idle();
        check("err_clr", 32'({err_ovf, err_udf}), 32'h0);

        // Wrap and concurrency on ch1
        wr(1, 8'hE0); wr(1, 8'hE1);
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_ch = 1; wr_data = 8'hA0 + 8'(i);
            rd_req = 1'b1; rd_ch = 1;
            step();
            idle();
            check("wrap_valid", 32'(rd_valid), 32'h1);
            check("wrap_data", 32'(rd_data),
                  (i == 0) ? 32'hE0 : (i == 1) ? 32'hE1 : 32'(8'hA0 + 8'(i - 2)));
            check_count("wrap_count", 1, 2);
        end
        rd(1); check("wrap_tail0", 32'(rd_data), 32'hA8);
        rd(1); check("wrap_tail1", 32'(rd_data), 32'hA9);
        check("ch1_drained", 32'(empty[1]), 32'h1);

        // Cross-channel: write ch1 while reading ch0
        wr(0, 8'h77);
        wr_valid = 1'b1; wr_ch = 1; wr_data = 8'hB0; rd_req = 1'b1; rd_ch = 0;
        step(); idle();
        check("cross_rd_data", 32'(rd_data), 32'h77);
        check("cross_empty", 32'(empty), 32'h1);
        check_count("cross_ch1_cnt", 1, 1);

        // Full ch0 with concurrent read: write rejected; error set wins over clear
        wr(0, 8'hC1); wr(0, 8'hC2); wr(0, 8'hC3); wr(0, 8'hC4);
        wr_valid = 1'b1; wr_ch = 0; wr_data = 8'hC5; rd_req = 1'b1; rd_ch = 0; err_clr = 1'b1;
        step(); idle();
        check("fullrw_rd_data", 32'(rd_data), 32'hC1);
        check("fullrw_ovf", 32'(err_ovf), 32'h1);
        check_count("fullrw_count", 0, 3);
        err_clr = 1'b1; step(); idle();
        check("clr2", 32'(err_ovf), 32'h0);

        // Flush ch0 with concurrent write
        flush = 2'b01; wr_valid = 1'b1; wr_ch = 0; wr_data = 8'hCC;
        #1;
        check("flush_wr_ready", 32'(wr_ready), 32'h0);
        step(); idle();
        check_count("flush_count", 0, 0);
        check("flush_empty", 32'(empty[0]), 32'h1);
        check("flush_no_err", 32'({err_ovf, err_udf}), 32'h0);
        check_count("flush_ch1_cnt", 1, 1);
        wr(0, 8'hD0);
        rd(0); check("post_flush_d", 32'(rd_data), 32'hD0);
        check("post_flush_empty", 32'(empty[0]), 32'h1);
        rd(1); check("ch1_b0", 32'(rd_data), 32'hB0);

        // Empty ch0 read with concurrent write: read rejected, write accepted
        wr_valid = 1'b1; wr_ch = 0; wr_data = 8'hD1; rd_req = 1'b1; rd_ch = 0;
        step(); idle();
        check("emptyrw_valid", 32'(rd_valid), 32'h0);
        check("emptyrw_udf", 32'(err_udf), 32'h1);
        check_count("emptyrw_count", 0, 1);

        // Reset asserted between edges
        wr(0, 8'hD2);
        rst_n = 1'b0;
        check_count("rst_mid_hold", 0, 2);
        check("rst_mid_udf", 32'(err_udf), 32'h1);
        step();
        check("rst2_empty", 32'(empty), 32'h3);
        check("rst2_errs", 32'({err_ovf, err_udf}), 32'h0);
        check("rst2_rd_data", 32'(rd_data), 32'h0);
        check_count("rst2_count", 0, 0);
        rst_n = 1'b1;
        wr(1, 8'hE5);
        rd(1);
        check("post_rst_v", 32'(rd_valid), 32'h1);
        check("post_rst_d", 32'(rd_data), 32'hE5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
